// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transmitter
//  Description : 8N1-style UART serializer. Sends a start bit, DATA_BITS data
//                bits (LSB first) and one stop bit, pacing every bit with
//                TICKS_PER_BIT pulses of the shared oversampled baud tick.
//                Single-cycle start strobe in, registered busy/done status out.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int DATA_BITS     = 8,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_data_byte,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_tx_done
);

  // Counter widths; a floor of one bit keeps degenerate parameter values legal.
  localparam int c_CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);

  // One-hot frame states.
  localparam logic [3:0] c_IDLE  = 4'b0001;
  localparam logic [3:0] c_START = 4'b0010;
  localparam logic [3:0] c_DATA  = 4'b0100;
  localparam logic [3:0] c_STOP  = 4'b1000;

  logic [3:0]           r_state;
  logic [c_CNT_W-1:0]   r_tick_cnt;
  logic [c_IDX_W-1:0]   r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_tx_done;

  logic                 w_period_end;
  logic                 w_last_bit;
  logic [DATA_BITS-1:0] w_shift_next;

  // A bit period ends on the tick that sees the counter at its last value.
  assign w_period_end = i_tick && (r_tick_cnt == c_TICK_LAST);
  assign w_last_bit   = (r_bit_idx == c_IDX_LAST);
  // Next data bit to drive is bit 0 of the already-shifted register.
  assign w_shift_next = r_shift >> 1;

  // Frame sequencing plus registered line level and status flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= c_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (i_tx_start) begin
            r_state <= c_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        c_START: begin
          if (w_period_end) begin
            r_state <= c_DATA;
            r_tx    <= r_shift[0];
          end
        end
        c_DATA: begin
          if (w_period_end) begin
            if (w_last_bit) begin
              r_state <= c_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx <= w_shift_next[0];
            end
          end
        end
        c_STOP: begin
          if (w_period_end) begin
            r_state   <= c_IDLE;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b1;
          end
        end
        default: begin
          // Unreachable encodings recover to a quiet idle line.
          r_state <= c_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tick counter: held at zero while idle, so a tick coinciding with the
  // accept cycle is never credited to the start bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tick_cnt <= '0;
    end else if (r_state == c_IDLE) begin
      r_tick_cnt <= '0;
    end else if (i_tick) begin
      if (r_tick_cnt == c_TICK_LAST) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + c_CNT_ONE;
      end
    end
  end

  // Payload capture on accept, then shift-out and bit indexing during DATA.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else begin
      if ((r_state == c_IDLE) && i_tx_start) begin
        r_shift   <= i_data_byte;
        r_bit_idx <= '0;
      end else if ((r_state == c_DATA) && w_period_end) begin
        r_shift <= w_shift_next;
        if (w_last_bit) begin
          r_bit_idx <= '0;
        end else begin
          r_bit_idx <= r_bit_idx + c_IDX_ONE;
        end
      end
    end
  end

  assign o_tx      = r_tx;
  assign o_busy    = r_busy;
  assign o_tx_done = r_tx_done;

endmodule
`default_nettype wire
